// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative radix-2 Booth multiplier, signed or unsigned operands.
// Ports: clk, rst (async, high), flush; in_valid/in_ready with is_signed, in1, in2;
//        out_valid/out_ready with out (2*WIDTH, registered); ovf only when the
//        MULT_OVF_FLAG_EN macro is defined (product does not fit in WIDTH bits).
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out
`ifdef MULT_OVF_FLAG_EN
    ,
    output logic               ovf
`endif
);

    localparam int W1 = WIDTH + 1;
    localparam int CW = $clog2(W1 + 1);
    localparam logic [CW-1:0] LAST = CW'(W1 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [W1:0]        mcand_q;
    logic [W1:0]        acc_q;
    logic [W1-1:0]      q_q;
    logic               qm1_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] out_q;

    // Operands widened by one bit so unsigned values stay positive
    logic [W1-1:0]      ext1;
    logic [W1-1:0]      ext2;

    // Result of the Booth step for the current cycle
    logic [W1:0]        sum_d;
    logic [W1:0]        acc_d;
    logic [W1-1:0]      q_d;
    logic               qm1_d;
    logic [2*WIDTH-1:0] out_d;

    assign ext1 = {is_signed & in1[WIDTH-1], in1};
    assign ext2 = {is_signed & in2[WIDTH-1], in2};

    // The extra accumulator bit keeps add/subtract of the most
    // negative multiplicand from wrapping.
    always_comb begin
        sum_d = acc_q;
        case ({q_q[0], qm1_q})
            2'b01:   sum_d = acc_q + mcand_q;
            2'b10:   sum_d = acc_q - mcand_q;
            default: sum_d = acc_q;
        endcase
        {acc_d, q_d, qm1_d} = {sum_d[W1], sum_d, q_q};
        out_d = {acc_d[WIDTH-2:0], q_d};
    end

`ifdef MULT_OVF_FLAG_EN
    logic sgn_q;
    logic ovf_q;
    logic ovf_d;
    logic [WIDTH:0] hi_s;

    assign hi_s = out_d[2*WIDTH-1:WIDTH-1];

    always_comb begin
        if (sgn_q)
            ovf_d = !((&hi_s) || !(|hi_s));
        else
            ovf_d = |out_d[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (!flush) begin
            if (state_q == S_IDLE && in_valid)
                sgn_q <= is_signed;
            if (state_q == S_RUN && cnt_q == LAST)
                ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            out_q       <= '0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand_q    <= {ext1[W1-1], ext1};
                        q_q        <= ext2;
                        acc_q      <= '0;
                        qm1_q      <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        out_q       <= out_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule
